fir_mac_engine: RTL and testbench
=================================

// Module: fir_mac_engine
// PURPOSE
//  Parametrised sequential FIR filter: TAPS-deep sample delay line, writable coefficient bank, one shared MAC.
//  Successor to the fixed 5-register/ROM FIR: tap count and widths are generic, coefficients are writable,
//  input has a valid/ready handshake, and output is rounded and saturated with an overflow flag.
//  Sits between a sample source (ROM or ADC front end) and downstream DSP/DAC logic.
// PARAMETERS
//  DATA_W  16  sample width, signed two's complement
//  COEF_W  16  coefficient width, signed
//  TAPS     8  number of taps (>=2); delay line depth = TAPS
//  ACC_W   40  accumulator width; must be >= DATA_W+COEF_W+clog2(TAPS)
//  OUT_W   16  output sample width, signed
//  SH_W     6  width of shift input; must satisfy 2**SH_W > ACC_W
// PORTS
//  clk        in   1              rising-edge clock
//  rst        in   1              asynchronous active-high reset
//  x_valid    in   1              new input sample offered
//  x_data     in   DATA_W         input sample
//  x_ready    out  1              engine can accept a sample (high only in IDLE)
//  coef_we    in   1              coefficient write strobe
//  coef_addr  in   clog2(TAPS)    coefficient index (0 multiplies newest sample)
//  coef_data  in   COEF_W         coefficient value
//  shift      in   SH_W           output scaling: arithmetic right shift of accumulator
//  y_valid    out  1              one-cycle pulse: y_data valid
//  y_data     out  OUT_W          filtered output sample (held until next y_valid)
//  y_sat      out  1              saturation occurred on the current y_data (held with y_data)
//  busy       out  1              MAC sequence in progress
// BEHAVIOUR
//  - Reset: state=IDLE; delay line, coefficients, accumulator, idx = 0; y_valid=0, y_data=0, y_sat=0,
//    busy=0; x_ready=1 after reset is released.
//  - FSM: IDLE -> MAC on (x_valid & x_ready); MAC -> OUT when idx==TAPS-1; OUT -> IDLE unconditionally.
//  - Accept edge (IDLE, x_valid=1): tap[0]<=x_data, tap[k]<=tap[k-1], oldest tap dropped; acc<=0; idx<=0.
//  - MAC: one product per cycle; acc <= acc + sext(tap[idx]*coef[idx]); idx++; TAPS cycles total.
//  - OUT: y_data, y_sat computed from final acc; y_valid=1 for exactly this one cycle.
//  - Latency: accept at edge 0 -> y_valid high in cycle TAPS+1; throughput 1 sample per TAPS+2 cycles.
//  - x_ready=0 and busy=1 in MAC and OUT; x_valid there is ignored (no sample loss in delay line, no queue).
//  - Scaling: shift sampled in OUT. If shift==0, r=acc; else r=(acc + (1<<(shift-1))) >>> shift (round
//    half up). If shift >= ACC_W, treat it as ACC_W-1. Rounding add is done at ACC_W+1 bits (no wrap).
//  - Saturation: if r > 2**(OUT_W-1)-1, y_data=max and y_sat=1; if r < -2**(OUT_W-1), y_data=min and
//    y_sat=1; else y_data=r[OUT_W-1:0] and y_sat=0.
//  - Coefficient writes: performed only when state==IDLE; while busy, coef_we is ignored (the bank stays
//    stable for the whole sequence). If coef_we and an accepted x_valid fall on the same IDLE edge, the
//    write lands and the new sequence uses the updated coefficient.
//  - Accumulator never wraps given the ACC_W constraint; no mid-sequence overflow handling is required.
//  - rst mid-sequence: immediate abort to reset state; no y_valid for the aborted sample.
// STRUCTURE
//  - fir_pkg: FSM state encoding (IDLE, MAC, OUT), clog2 function, sat/round helper function.
//  - Sub-module fir_delay_line (TAPS x DATA_W shift register with load enable and indexed read port);
//    FSM, coefficient bank, MAC and output stage stay in fir_mac_engine.
// TESTING
//  1 Impulse: coef[k]=k+1, shift=0, feed 1 then seven 0s -> y_data = 1,2,...,8 across successive outputs.
//  2 Latency/handshake: x_valid held high -> x_ready low TAPS+1 cycles per accept; y_valid in cycle 9 (TAPS=8).
//  3 Saturation: all coef=32767, x=32767 fed 8 times, shift=0 -> y_data=32767, y_sat=1;
//    x=-32768 repeated -> y_data=-32768, y_sat=1.
//  4 Rounding: single tap coef[0]=3, x=1, shift=1 -> 2 (1.5 rounds up); x=-1 -> -1 (-1.5 rounds half up).
//  5 Coef write while busy: coef_we during MAC ignored (output unchanged); same-edge write+accept is applied.
//  6 Reset mid-MAC: assert rst at idx=3 -> outputs 0, no y_valid; next impulse behaves exactly as in test 1.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR MAC engine.
//   fir_state_e : sequencing states (idle / multiply-accumulate / output)
//   clog2       : ceiling log2 for index widths
//   round_shr   : round-half-up arithmetic right shift on a widened accumulator
//   sat_clip    : clamp a rounded value into a signed OUT_W range, flagging saturation
package fir_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StMac,
        StOut
    } fir_state_e;

    // Container width for the output-stage helpers; accumulators up to 64 bits are supported.
    localparam int unsigned MAX_W = 64;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) begin
            r++;
        end
        return r;
    endfunction

    // One extra bit of headroom so the rounding add can never wrap.
    function automatic logic signed [MAX_W:0] round_shr(input logic signed [MAX_W-1:0] acc,
                                                        input int unsigned sh);
        logic signed [MAX_W:0] wide;
        logic signed [MAX_W:0] half;
        wide = {acc[MAX_W-1], acc};
        if (sh == 0) begin
            return wide;
        end
        half = {{MAX_W{1'b0}}, 1'b1};
        half = half <<< (sh - 1);
        wide = wide + half;
        return wide >>> sh;
    endfunction

    function automatic logic signed [MAX_W:0] sat_clip(input logic signed [MAX_W:0] r,
                                                       input int unsigned out_w,
                                                       output logic sat);
        logic signed [MAX_W:0] one;
        logic signed [MAX_W:0] hi;
        logic signed [MAX_W:0] lo;
        logic signed [MAX_W:0] res;
        one = {{MAX_W{1'b0}}, 1'b1};
        hi  = (one <<< (out_w - 1)) - one;
        lo  = ~hi;
        sat = 1'b0;
        res = r;
        if (r > hi) begin
            res = hi;
            sat = 1'b1;
        end else if (r < lo) begin
            res = lo;
            sat = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/fir_delay_line.sv
// TAPS-deep sample shift register with an indexed read port.
//   clk, rst : clock, asynchronous active-high reset (clears all taps)
//   load     : shift din into tap 0, every tap moves one place older, oldest dropped
//   din      : incoming sample
//   rd_idx   : tap to read (0 = newest)
//   rd_data  : selected tap contents
module fir_delay_line #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned TAPS   = 8,
    parameter int unsigned IDX_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] din,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] tap_q [TAPS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < int'(TAPS); k++) begin
                tap_q[k] <= '0;
            end
        end else if (load) begin
            tap_q[0] <= din;
            for (int k = 1; k < int'(TAPS); k++) begin
                tap_q[k] <= tap_q[k-1];
            end
        end
    end

    assign rd_data = tap_q[rd_idx];

endmodule

// File: rtl/fir_mac_engine.sv
// Sequential FIR filter: one shared multiply-accumulate walks the delay line, then the
// accumulator is rounded, shifted and saturated into the output sample.
//   clk, rst   : clock, asynchronous active-high reset
//   x_valid    : sample offered; taken when x_ready is high
//   x_data     : input sample (signed)
//   x_ready    : high only while idle
//   coef_we    : coefficient write strobe, honoured only while idle
//   coef_addr  : coefficient index (0 pairs with the newest sample)
//   coef_data  : coefficient value (signed)
//   shift      : arithmetic right shift applied to the accumulator at output time
//   y_valid    : one-cycle pulse marking a fresh y_data
//   y_data     : filtered sample, held until the next y_valid
//   y_sat      : saturation flag for the current y_data
//   busy       : a MAC sequence is in progress
module fir_mac_engine
    import fir_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned COEF_W = 16,
    parameter int unsigned TAPS   = 8,
    parameter int unsigned ACC_W  = 40,
    parameter int unsigned OUT_W  = 16,
    parameter int unsigned SH_W   = 6,
    localparam int unsigned IDX_W = clog2(TAPS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              x_valid,
    input  logic [DATA_W-1:0] x_data,
    output logic              x_ready,
    input  logic              coef_we,
    input  logic [IDX_W-1:0]  coef_addr,
    input  logic [COEF_W-1:0] coef_data,
    input  logic [SH_W-1:0]   shift,
    output logic              y_valid,
    output logic [OUT_W-1:0]  y_data,
    output logic              y_sat,
    output logic              busy
);

    fir_state_e state_q, state_d;

    logic [IDX_W-1:0]        idx_q, idx_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [COEF_W-1:0]       coef_q [TAPS];
    logic [OUT_W-1:0]        y_hold_q;
    logic                    y_sat_hold_q;

    logic                    accept;
    logic                    last_tap;
    logic [DATA_W-1:0]       tap_rd;
    logic signed [DATA_W+COEF_W-1:0] prod;

    logic signed [MAX_W-1:0] acc_ext;
    logic signed [MAX_W:0]   rounded;
    int unsigned             sh_eff;
    logic [OUT_W-1:0]        y_new;
    logic                    sat_new;

    assign accept   = (state_q == StIdle) && x_valid;
    assign last_tap = (idx_q == IDX_W'(TAPS - 1));
    assign prod     = $signed(tap_rd) * $signed(coef_q[idx_q]);

    fir_delay_line #(
        .DATA_W (DATA_W),
        .TAPS   (TAPS),
        .IDX_W  (IDX_W)
    ) u_delay_line (
        .clk     (clk),
        .rst     (rst),
        .load    (accept),
        .din     (x_data),
        .rd_idx  (idx_q),
        .rd_data (tap_rd)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (x_valid) state_d = StMac;
            StMac:   if (last_tap) state_d = StOut;
            StOut:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        x_ready = (state_q == StIdle);
        busy    = (state_q != StIdle);
        y_valid = (state_q == StOut);
        // Fresh result is driven straight from the accumulator during OUT, then held.
        y_data  = y_valid ? y_new : y_hold_q;
        y_sat   = y_valid ? sat_new : y_sat_hold_q;
    end

    // ---------------- MAC datapath ----------------
    always_comb begin
        acc_d = acc_q;
        idx_d = idx_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    acc_d = '0;
                    idx_d = '0;
                end
            end
            StMac: begin
                acc_d = acc_q + ACC_W'(prod);
                idx_d = last_tap ? '0 : idx_q + IDX_W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            idx_q <= '0;
        end else begin
            acc_q <= acc_d;
            idx_q <= idx_d;
        end
    end

    // Writes land only in IDLE so the bank is frozen for a whole sequence; a write on the
    // accept edge is visible to that sequence because tap 0 is read one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < int'(TAPS); k++) begin
                coef_q[k] <= '0;
            end
        end else if (state_q == StIdle && coef_we && 32'(coef_addr) < TAPS) begin
            coef_q[coef_addr] <= coef_data;
        end
    end

    // ---------------- Output stage ----------------
    always_comb begin
        acc_ext = MAX_W'(acc_q);
        sh_eff  = (32'(shift) >= ACC_W) ? ACC_W - 1 : 32'(shift);
        rounded = round_shr(acc_ext, sh_eff);
        sat_new = 1'b0;
        y_new   = OUT_W'(sat_clip(rounded, OUT_W, sat_new));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_hold_q     <= '0;
            y_sat_hold_q <= 1'b0;
        end else if (state_q == StOut) begin
            y_hold_q     <= y_new;
            y_sat_hold_q <= sat_new;
        end
    end

endmodule

// File: tb/tb_fir_mac_engine.sv
// Directed bench for fir_mac_engine (TAPS=8, 16-bit data/coef/output, 40-bit accumulator).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_fir_mac_engine;

    logic        clk;
    logic        rst;
    logic        x_valid;
    logic [15:0] x_data;
    logic        x_ready;
    logic        coef_we;
    logic [2:0]  coef_addr;
    logic [15:0] coef_data;
    logic [5:0]  shift;
    logic        y_valid;
    logic [15:0] y_data;
    logic        y_sat;
    logic        busy;

    int n_checks;
    int n_pass;

    longint y;
    longint s;
    int     lat;
    int     run, first_run, yv1, yv2, pulses, n;

    fir_mac_engine #(
        .DATA_W (16),
        .COEF_W (16),
        .TAPS   (8),
        .ACC_W  (40),
        .OUT_W  (16),
        .SH_W   (6)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .x_valid   (x_valid),
        .x_data    (x_data),
        .x_ready   (x_ready),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .shift     (shift),
        .y_valid   (y_valid),
        .y_data    (y_data),
        .y_sat     (y_sat),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic write_coef(input int a, input int v);
        coef_we   = 1'b1;
        coef_addr = 3'(a);
        coef_data = 16'(v);
        @(negedge clk);
        coef_we   = 1'b0;
    endtask

    task automatic set_ramp();
        for (int k = 0; k < 8; k++) write_coef(k, k + 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int m;
        m = 0;
        while (!x_ready && m < 50) begin
            @(negedge clk);
            m++;
        end
        if (!x_ready) check("ready_timeout", 0, 1);
    endtask

    // Offer one sample, optionally with a coefficient write on the accept edge (same_we) or
    // held throughout the busy period (busy_we); returns the output and the latency in cycles.
    task automatic push(input int x, input bit same_we, input bit busy_we, input int wa,
                        input int wv, output longint yo, output longint so, output int lo);
        wait_idle();
        x_valid = 1'b1;
        x_data  = 16'(x);
        if (same_we) begin
            coef_we   = 1'b1;
            coef_addr = 3'(wa);
            coef_data = 16'(wv);
        end
        @(negedge clk);
        x_valid = 1'b0;
        coef_we = 1'b0;
        if (busy_we) begin
            coef_we   = 1'b1;
            coef_addr = 3'(wa);
            coef_data = 16'(wv);
        end
        lo = 1;
        while (!y_valid && lo < 50) begin
            @(negedge clk);
            lo++;
        end
        coef_we = 1'b0;
        if (!y_valid) check("y_valid_timeout", 0, 1);
        yo = longint'($signed(y_data));
        so = longint'(y_sat);
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst       = 1'b1;
        x_valid   = 1'b0;
        x_data    = '0;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        shift     = '0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_y_valid", longint'(y_valid), 0);
        check("rst_busy", longint'(busy), 0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_x_ready", longint'(x_ready), 1);
        check("rst_y_data", longint'(y_data), 0);
        check("rst_y_sat", longint'(y_sat), 0);

        // 1: impulse response walks out the ramp coefficients
        set_ramp();
        shift = 6'd0;
        for (int i = 0; i < 8; i++) begin
            push((i == 0) ? 1 : 0, 1'b0, 1'b0, 0, 0, y, s, lat);
            check($sformatf("impulse_y%0d", i), y, i + 1);
            check($sformatf("impulse_sat%0d", i), s, 0);
            if (i == 0) begin
                check("latency", lat, 9);
                @(negedge clk);
                check("y_valid_pulse", longint'(y_valid), 0);
                check("y_data_hold", longint'($signed(y_data)), 1);
            end
        end

        // 2: x_valid held high
        wait_idle();
        x_data    = '0;
        x_valid   = 1'b1;
        run       = 0;
        first_run = -1;
        yv1       = -1;
        yv2       = -1;
        for (int i = 1; i <= 25; i++) begin
            @(negedge clk);
            if (!x_ready) begin
                run++;
            end else begin
                if (run > 0 && first_run < 0) first_run = run;
                run = 0;
            end
            if (y_valid) begin
                if (yv1 < 0) yv1 = i;
                else if (yv2 < 0) yv2 = i;
            end
        end
        x_valid = 1'b0;
        check("ready_low_run", first_run, 9);
        check("first_y_valid_cycle", yv1, 9);
        check("y_valid_period", yv2 - yv1, 10);
        wait_idle();

        // 3: saturation at both rails
        do_reset();
        for (int k = 0; k < 8; k++) write_coef(k, 32767);
        for (int i = 0; i < 8; i++) push(32767, 1'b0, 1'b0, 0, 0, y, s, lat);
        check("sat_pos_y", y, 32767);
        check("sat_pos_flag", s, 1);
        for (int i = 0; i < 8; i++) push(-32768, 1'b0, 1'b0, 0, 0, y, s, lat);
        check("sat_neg_y", y, -32768);
        check("sat_neg_flag", s, 1);

        // 4: rounding on a single tap
        do_reset();
        write_coef(0, 3);
        shift = 6'd1;
        push(1, 1'b0, 1'b0, 0, 0, y, s, lat);
        check("round_pos_1p5", y, 2);
        push(-1, 1'b0, 1'b0, 0, 0, y, s, lat);
        check("round_neg_1p5", y, -1);
        shift = 6'd2;
        push(2, 1'b0, 1'b0, 0, 0, y, s, lat);
        check("round_shift2", y, 2);
        shift = 6'd0;
        push(-5, 1'b0, 1'b0, 0, 0, y, s, lat);
        check("no_shift_neg", y, -15);
        check("no_shift_sat", s, 0);
        shift = 6'd63;
        push(32767, 1'b0, 1'b0, 0, 0, y, s, lat);
        check("shift_clamp", y, 0);
        shift = 6'd0;

        // 5: coefficient writes while busy are dropped; same-edge write is used
        do_reset();
        set_ramp();
        push(1, 1'b0, 1'b1, 0, 100, y, s, lat);
        check("busy_write_out", y, 1);
        push(0, 1'b1, 1'b0, 1, 50, y, s, lat);
        check("same_edge_write", y, 50);
        push(1, 1'b0, 1'b0, 0, 0, y, s, lat);
        check("busy_write_ignored", y, 4);

        // 6: reset in the middle of a MAC sequence
        write_coef(1, 2);
        wait_idle();
        x_valid = 1'b1;
        x_data  = 16'd1;
        @(negedge clk);
        x_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_y_valid", longint'(y_valid), 0);
        check("abort_busy", longint'(busy), 0);
        check("abort_y_data", longint'(y_data), 0);
        check("abort_y_sat", longint'(y_sat), 0);
        @(negedge clk);
        rst    = 1'b0;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (y_valid) pulses++;
        end
        check("abort_no_y_valid", pulses, 0);
        set_ramp();
        for (int i = 0; i < 8; i++) begin
            push((i == 0) ? 1 : 0, 1'b0, 1'b0, 0, 0, y, s, lat);
            check($sformatf("post_abort_y%0d", i), y, i + 1);
        end
        check("post_abort_latency", lat, 9);

        n = n_checks;
        $display("%0d/%0d checks passed", n_pass, n);
        $finish;
    end

endmodule
